controle_rodadas: RTL and testbench
===================================

# controle_rodadas

Moore control unit that sequences one mod-M counter instance (`contador_m_v`, M and N set by the parent) as a per-round response timer. It runs a fixed number of rounds. Each round waits for a `jogada` pulse and gives up when the counter reaches terminal count. It sits beside the counter in the game datapath: it drives the counter's synchronous clear and count enable, consumes its `fim`/`meio` flags, and reports round progress, success or timeout to the top level.

## Interface
- `RODADAS`, 4: number of rounds per game; 1..2^RW.
- `RW`, 2: width of `rodada`; 2^RW >= RODADAS.

Ports:
- `clock` in 1: single clock; all state changes on the rising edge.
- `reset_n` in 1: reset, synchronous, active-low.
- `iniciar` in 1: start request, level-sampled.
- `jogada` in 1: player response, one-cycle pulse.
- `fim_c` in 1: counter terminal count (Q == M-1).
- `meio_c` in 1: counter half-count flag.
- `zera_c` out 1: to the counter's `zera_s`.
- `conta_c` out 1: to the counter's `conta`.
- `rodada` out RW: index of the current round, 0-based.
- `alerta` out 1: sticky flag; half of the round time has elapsed.
- `pronto` out 1: game finished.
- `timeout` out 1: game ended by timeout.
- `db_estado` out 4: state encoding, for debug displays.

## Operation
State encodings:
- `inicial` = 0
- `preparacao` = 1
- `espera` = 2
- `registra` = 3
- `proxima` = 4
- `fim_ok` = 5
- `fim_timeout` = 6
- Unused encodings go to `inicial`.

Transitions:
- `inicial`: `iniciar`=1 → `preparacao`; otherwise stay.
- `preparacao`: unconditionally → `espera`.
- `espera`:
  - `jogada`=1 → `registra`. This applies even if `fim_c`=1 in the same cycle: jogada wins.
  - Else `fim_c`=1 → `fim_timeout`.
  - Else stay.
- `registra`: `rodada` == RODADAS-1 → `fim_ok`; otherwise → `proxima`.
- `proxima`: unconditionally → `espera`.
- `fim_ok`, `fim_timeout`: `iniciar`=1 → `preparacao`; otherwise hold.

Outputs (Moore, decoded from registered state unless noted):
- `zera_c`=1 only in `preparacao` and `proxima`.
- `conta_c`=1 only in `espera`.
- `pronto`=1 in `fim_ok` and `fim_timeout`.
- `timeout`=1 only in `fim_timeout`.

Registered state:
- `rodada`:
  - Cleared to 0 on the clock edge leaving `inicial`, `fim_ok` or `fim_timeout` into `preparacao`.
  - Incremented by 1 on the edge leaving `proxima`.
  - Held otherwise. It never wraps, because `registra` bounds it at RODADAS-1.
- `alerta`:
  - Set on any edge where state is `espera` and `meio_c`=1.
  - Cleared on any edge where `zera_c`=1.
  - Held otherwise, including in `fim_*`, so the last round's value stays visible.

Other rules:
- `iniciar` held high in `fim_*` restarts immediately; no edge detection is required.
- `jogada` outside `espera` is ignored.
- Reset (`reset_n`=0 at a rising edge), from any state including mid-round, produces:
  - state = `inicial`
  - `rodada` = 0
  - `alerta` = 0
  - All outputs 0, and `db_estado` = 0.

## Timing
- One state transition per clock; no combinational path from inputs to outputs.
- Start latency: `iniciar` sampled at edge k → `zera_c`=1 during cycle k+1 → `conta_c`=1 from edge k+2.
- The counter is at Q=0 on entering `espera`.
  - With counter M, `fim_c` rises after M-1 cycles in `espera`.
  - `timeout`=1 one edge later.
  - Total time from entering `espera` to `timeout` is M cycles.
- Jogada latency: pulse sampled at edge j:
  - `registra` during j+1, with `conta_c`=0 so the counter freezes.
  - `proxima` (`zera_c`=1) or `fim_ok` during j+2.
  - The next `espera` begins at j+3.
- `pronto` asserts exactly 2 cycles after the final accepted `jogada` edge.

## Test plan
Bench: controller plus `contador_m_v` with M=100, N=7, and RODADAS=4; clock period 20 ns.

1. Reset:
   - Stimulus: `reset_n`=0 for 2 cycles in `espera` with `rodada`=2 and `alerta`=1.
   - Required: next cycle `db_estado`=0, `rodada`=0, `alerta`=0, all outputs 0.
   - Required: `jogada` pulses in `inicial` cause no change.
2. Full success:
   - Stimulus: `iniciar` pulse, then `jogada` 10 cycles after each entry to `espera`, four times.
   - Required: `rodada` steps 0→1→2→3.
   - Required: `zera_c` pulses once per `proxima` (3 times, plus 1 in `preparacao`).
   - Required: `pronto`=1 and `timeout`=0 two cycles after the 4th jogada; `alerta`=0 throughout.
3. Timeout:
   - Stimulus: `iniciar`, then no `jogada`.
   - Required: `conta_c`=1 for exactly 100 cycles.
   - Required: `alerta` rises once Q reaches the half count.
   - Required: `timeout`=1 and `pronto`=1 in `fim_timeout` (`db_estado`=6), with `rodada`=0.
4. Simultaneous:
   - Stimulus: `jogada` in the same cycle that `fim_c`=1 (Q=99) in round 1.
   - Required: state goes to `registra`, then `proxima`; no timeout; `rodada`=2 afterwards; `alerta` cleared by `zera_c`.
5. Restart:
   - Stimulus: from `fim_timeout`, hold `iniciar`=1.
   - Required: next cycle `preparacao` with `zera_c`=1 and `rodada`=0; the following cycle `espera` with the counter at Q=0.

Source files
------------

// File: rtl/controle_rodadas_if.sv
// Bundles the controller's sideband signals: game control inputs, counter
// flags, counter commands and round status towards the top level.
interface controle_rodadas_if #(
  parameter int RW = 2
) ();
  logic          iniciar;
  logic          jogada;
  logic          fim_c;
  logic          meio_c;
  logic          zera_c;
  logic          conta_c;
  logic [RW-1:0] rodada;
  logic          alerta;
  logic          pronto;
  logic          timeout;
  logic [3:0]    db_estado;

  modport master (
    output iniciar, jogada, fim_c, meio_c,
    input  zera_c, conta_c, rodada, alerta, pronto, timeout, db_estado
  );

  modport slave (
    input  iniciar, jogada, fim_c, meio_c,
    output zera_c, conta_c, rodada, alerta, pronto, timeout, db_estado
  );
endinterface

// File: rtl/controle_rodadas.sv
// Moore round sequencer: times each round with an external mod-M counter,
// advances on a player response and ends the game on success or timeout.
module controle_rodadas #(
  parameter int RODADAS = 4,
  parameter int RW      = 2
) (
  input  logic                clock,
  input  logic                reset_n,
  controle_rodadas_if.slave   bus
);
  typedef enum logic [3:0] {
    INICIAL     = 4'd0,
    PREPARACAO  = 4'd1,
    ESPERA      = 4'd2,
    REGISTRA    = 4'd3,
    PROXIMA     = 4'd4,
    FIM_OK      = 4'd5,
    FIM_TIMEOUT = 4'd6
  } estado_t;

  localparam logic [RW-1:0] ULTIMA = RW'(RODADAS - 1);

  estado_t       r_estado;
  estado_t       w_proximo;
  logic [RW-1:0] r_rodada;
  logic          r_alerta;
  logic          w_zera;
  logic          w_conta;
  logic          w_pronto;
  logic          w_timeout;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_estado <= INICIAL;
    end else begin
      r_estado <= w_proximo;
    end
  end

  always_comb begin
    w_proximo = INICIAL;
    unique case (r_estado)
      INICIAL:     w_proximo = bus.iniciar ? PREPARACAO : INICIAL;
      PREPARACAO:  w_proximo = ESPERA;
      // A response in the same cycle as terminal count still counts.
      ESPERA: begin
        if (bus.jogada)     w_proximo = REGISTRA;
        else if (bus.fim_c) w_proximo = FIM_TIMEOUT;
        else                w_proximo = ESPERA;
      end
      REGISTRA:    w_proximo = (r_rodada == ULTIMA) ? FIM_OK : PROXIMA;
      PROXIMA:     w_proximo = ESPERA;
      FIM_OK:      w_proximo = bus.iniciar ? PREPARACAO : FIM_OK;
      FIM_TIMEOUT: w_proximo = bus.iniciar ? PREPARACAO : FIM_TIMEOUT;
      default:     w_proximo = INICIAL;
    endcase
  end

  always_comb begin
    w_zera    = (r_estado == PREPARACAO) || (r_estado == PROXIMA);
    w_conta   = (r_estado == ESPERA);
    w_pronto  = (r_estado == FIM_OK) || (r_estado == FIM_TIMEOUT);
    w_timeout = (r_estado == FIM_TIMEOUT);
  end

  // PREPARACAO is only ever entered from INICIAL or one of the end states.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_rodada <= '0;
      r_alerta <= 1'b0;
    end else begin
      if (w_proximo == PREPARACAO) begin
        r_rodada <= '0;
      end else if (r_estado == PROXIMA) begin
        r_rodada <= r_rodada + RW'(1);
      end

      if (w_zera) begin
        r_alerta <= 1'b0;
      end else if ((r_estado == ESPERA) && bus.meio_c) begin
        r_alerta <= 1'b1;
      end
    end
  end

  assign bus.zera_c    = w_zera;
  assign bus.conta_c   = w_conta;
  assign bus.rodada    = r_rodada;
  assign bus.alerta    = r_alerta;
  assign bus.pronto    = w_pronto;
  assign bus.timeout   = w_timeout;
  assign bus.db_estado = r_estado;
endmodule

// File: tb/tb_controle_rodadas.sv
// Bench for controle_rodadas with a behavioural mod-100 round timer beside it.
module tb_controle_rodadas;
  localparam int M       = 100;
  localparam int N       = 7;
  localparam int RODADAS = 4;
  localparam int RW      = 2;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #10 clock = ~clock;

  controle_rodadas_if #(.RW(RW)) bus ();

  controle_rodadas #(.RODADAS(RODADAS), .RW(RW)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Round timer: mod-M counter with synchronous clear
  logic [N-1:0] q;
  always @(posedge clock) begin
    if (!reset_n || bus.zera_c) q <= '0;
    else if (bus.conta_c)       q <= (q == N'(M - 1)) ? '0 : q + 1'b1;
  end
  assign bus.fim_c  = (q == N'(M - 1));
  assign bus.meio_c = (q == N'(M / 2));

  // Reference model: game phases with elapsed round time counted directly
  typedef enum int {OCIOSO, LIMPA, AGUARDA, ACEITA, AVANCA, GANHOU, PERDEU} fase_t;
  fase_t m_fase   = OCIOSO;
  int    m_rod    = 0;
  int    m_tempo  = 0;
  bit    m_alerta = 1'b0;

  always @(posedge clock) begin
    if (!reset_n) begin
      m_fase <= OCIOSO; m_rod <= 0; m_tempo <= 0; m_alerta <= 1'b0;
    end else begin
      case (m_fase)
        OCIOSO, GANHOU, PERDEU:
          if (bus.iniciar) begin m_fase <= LIMPA; m_rod <= 0; end
        LIMPA: begin m_fase <= AGUARDA; m_tempo <= 0; m_alerta <= 1'b0; end
        AGUARDA: begin
          if (m_tempo == M / 2) m_alerta <= 1'b1;
          if (bus.jogada)             m_fase <= ACEITA;
          else if (m_tempo == M - 1)  m_fase <= PERDEU;
          else                        m_tempo <= m_tempo + 1;
        end
        ACEITA: m_fase <= (m_rod == RODADAS - 1) ? GANHOU : AVANCA;
        AVANCA: begin m_fase <= AGUARDA; m_rod <= m_rod + 1; m_tempo <= 0; m_alerta <= 1'b0; end
        default: m_fase <= OCIOSO;
      endcase
    end
  end

  function automatic logic [10:0] esperado();
    logic z, c, p, t;
    z = (m_fase == LIMPA) || (m_fase == AVANCA);
    c = (m_fase == AGUARDA);
    p = (m_fase == GANHOU) || (m_fase == PERDEU);
    t = (m_fase == PERDEU);
    return {z, c, 2'(m_rod), m_alerta, p, t, 4'(m_fase)};
  endfunction

  function automatic logic [10:0] atual();
    return {bus.zera_c, bus.conta_c, bus.rodada, bus.alerta, bus.pronto, bus.timeout, bus.db_estado};
  endfunction

  int checks = 0;
  int errors = 0;
  int zera_cnt = 0;
  bit alerta_visto = 1'b0;

  task automatic chk(input string nome, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %0h expected %0h at %0t", nome, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    if (bus.zera_c === 1'b1) zera_cnt++;
    if (bus.alerta === 1'b1) alerta_visto = 1'b1;
    chk("model", 32'(atual()), 32'(esperado()));
  endtask

  typedef struct {
    bit         rst_n, ini, jog;
    logic [3:0] est;
    logic [1:0] rod;
    bit         z, c, p, t;
  } vec_t;
  vec_t tab[20];

  initial begin
    int n;
    int conta_n;
    int primeiro_alerta;
    bus.iniciar = 1'b0;
    bus.jogada  = 1'b0;

    // rst_n ini jog | est rod z c p t
    tab[0]  = '{0, 0, 0, 4'd0, 2'd0, 0, 0, 0, 0};
    tab[1]  = '{0, 0, 0, 4'd0, 2'd0, 0, 0, 0, 0};
    tab[2]  = '{1, 0, 1, 4'd0, 2'd0, 0, 0, 0, 0};
    tab[3]  = '{1, 1, 0, 4'd1, 2'd0, 1, 0, 0, 0};
    tab[4]  = '{1, 0, 0, 4'd2, 2'd0, 0, 1, 0, 0};
    tab[5]  = '{1, 0, 1, 4'd3, 2'd0, 0, 0, 0, 0};
    tab[6]  = '{1, 0, 0, 4'd4, 2'd0, 1, 0, 0, 0};
    tab[7]  = '{1, 0, 0, 4'd2, 2'd1, 0, 1, 0, 0};
    tab[8]  = '{1, 0, 1, 4'd3, 2'd1, 0, 0, 0, 0};
    tab[9]  = '{1, 0, 0, 4'd4, 2'd1, 1, 0, 0, 0};
    tab[10] = '{1, 0, 0, 4'd2, 2'd2, 0, 1, 0, 0};
    tab[11] = '{1, 0, 1, 4'd3, 2'd2, 0, 0, 0, 0};
    tab[12] = '{1, 0, 0, 4'd4, 2'd2, 1, 0, 0, 0};
    tab[13] = '{1, 0, 0, 4'd2, 2'd3, 0, 1, 0, 0};
    tab[14] = '{1, 0, 1, 4'd3, 2'd3, 0, 0, 0, 0};
    tab[15] = '{1, 0, 0, 4'd5, 2'd3, 0, 0, 1, 0};
    tab[16] = '{1, 0, 1, 4'd5, 2'd3, 0, 0, 1, 0};
    tab[17] = '{1, 1, 0, 4'd1, 2'd0, 1, 0, 0, 0};
    tab[18] = '{1, 0, 0, 4'd2, 2'd0, 0, 1, 0, 0};
    tab[19] = '{0, 0, 0, 4'd0, 2'd0, 0, 0, 0, 0};

    for (int i = 0; i < 20; i++) begin
      reset_n = tab[i].rst_n; bus.iniciar = tab[i].ini; bus.jogada = tab[i].jog;
      tick();
      chk($sformatf("vec%0d", i),
          32'({bus.db_estado, bus.rodada, bus.zera_c, bus.conta_c, bus.pronto, bus.timeout}),
          32'({tab[i].est, tab[i].rod, tab[i].z, tab[i].c, tab[i].p, tab[i].t}));
      $display("vec %0d: rst_n=%0b ini=%0b jog=%0b -> estado=%0d rodada=%0d", i,
               tab[i].rst_n, tab[i].ini, tab[i].jog, bus.db_estado, bus.rodada);
    end
    reset_n = 1'b1; bus.iniciar = 1'b0; bus.jogada = 1'b0;
    tick();

    // Full success: response 10 cycles into each round
    zera_cnt = 0; alerta_visto = 1'b0;
    bus.iniciar = 1'b1; tick(); bus.iniciar = 1'b0;
    tick();
    for (int r = 0; r < RODADAS; r++) begin
      chk("succ_espera", bus.db_estado, 4'd2);
      chk("succ_rodada", bus.rodada, r);
      repeat (10) tick();
      bus.jogada = 1'b1; tick(); bus.jogada = 1'b0;
      chk("succ_registra_pronto", bus.pronto, 1'b0);
      tick();
      if (r < RODADAS - 1) tick();
    end
    chk("succ_pronto", bus.pronto, 1'b1);
    chk("succ_timeout", bus.timeout, 1'b0);
    chk("succ_estado", bus.db_estado, 4'd5);
    chk("succ_zera_pulsos", zera_cnt, 4);
    chk("succ_alerta_nunca", alerta_visto, 1'b0);
    $display("success game: rodada=%0d pronto=%0b zera pulses=%0d", bus.rodada, bus.pronto, zera_cnt);

    // Timeout: no response at all
    bus.iniciar = 1'b1; tick(); bus.iniciar = 1'b0;
    tick();
    conta_n = (bus.conta_c === 1'b1) ? 1 : 0;
    primeiro_alerta = -1;
    n = 0;
    while (bus.db_estado !== 4'd6 && n < 300) begin
      tick(); n++;
      if (bus.conta_c === 1'b1) conta_n++;
      if (bus.alerta === 1'b1 && primeiro_alerta < 0) primeiro_alerta = n;
    end
    chk("to_conta_ciclos", conta_n, M);
    chk("to_alerta_ciclo", primeiro_alerta, M / 2 + 1);
    chk("to_estado", bus.db_estado, 4'd6);
    chk("to_flags", 32'({bus.timeout, bus.pronto, bus.alerta}), 32'(3'b111));
    chk("to_rodada", bus.rodada, 0);
    $display("timeout game: conta cycles=%0d alerta at cycle %0d", conta_n, primeiro_alerta);

    // Restart with iniciar held high
    bus.iniciar = 1'b1; tick();
    chk("rs_estado", bus.db_estado, 4'd1);
    chk("rs_zera", bus.zera_c, 1'b1);
    chk("rs_rodada", bus.rodada, 0);
    tick(); bus.iniciar = 1'b0;
    chk("rs_espera", bus.db_estado, 4'd2);
    chk("rs_q0", q, 0);
    $display("restart: estado=%0d q=%0d", bus.db_estado, q);

    // Response on the same cycle as terminal count, round 1
    bus.jogada = 1'b1; tick(); bus.jogada = 1'b0;
    tick(); tick();
    chk("sim_rodada1", bus.rodada, 1);
    n = 0;
    while (q !== N'(M - 1) && n < 150) begin tick(); n++; end
    chk("sim_fim_c", bus.fim_c, 1'b1);
    chk("sim_alerta_set", bus.alerta, 1'b1);
    bus.jogada = 1'b1; tick(); bus.jogada = 1'b0;
    chk("sim_registra", bus.db_estado, 4'd3);
    tick();
    chk("sim_proxima", 32'({bus.db_estado, bus.timeout}), 32'({4'd4, 1'b0}));
    tick();
    chk("sim_espera", bus.db_estado, 4'd2);
    chk("sim_rodada2", bus.rodada, 2);
    chk("sim_alerta_clr", bus.alerta, 1'b0);
    $display("simultaneous: estado=%0d rodada=%0d alerta=%0b", bus.db_estado, bus.rodada, bus.alerta);

    // Reset mid-round with rodada=2 and alerta=1
    n = 0;
    while (bus.alerta !== 1'b1 && n < 100) begin tick(); n++; end
    chk("rst_pre_alerta", bus.alerta, 1'b1);
    reset_n = 1'b0; tick(); tick(); reset_n = 1'b1;
    chk("rst_outputs", 32'(atual()), 32'(0));
    for (int i = 0; i < 3; i++) begin
      bus.jogada = 1'b1; tick(); bus.jogada = 1'b0; tick();
    end
    chk("rst_jogada_ignorada", bus.db_estado, 4'd0);
    $display("reset: estado=%0d rodada=%0d alerta=%0b", bus.db_estado, bus.rodada, bus.alerta);

    // Random play against the reference model
    for (int i = 0; i < 4000; i++) begin
      reset_n     = ($urandom_range(599) != 0);
      bus.iniciar = ($urandom_range(9) == 0);
      bus.jogada  = ($urandom_range(29) == 0);
      tick();
    end
    $display("random play: 4000 cycles compared against model");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
